esw_in_arb: RTL and testbench

- Packet-level round-robin arbiter that merges four ingress packet queues into the single switch-engine input stream (data/data_wr/valid/valid_wr).
- Each requester is a show-ahead packet data FIFO plus a per-packet valid FIFO.
- The block forwards whole packets only, never interleaves them, and honours downstream almost-full backpressure.
- It sits between the per-port ingress buffers and the switch-engine input.

---
 rtl/esw_pkg.sv | 23 ++
 rtl/esw_rr_pick.sv | 34 +++
 rtl/esw_in_arb.sv | 191 +++++++++++++++++++
 tb/tb_esw_in_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esw_pkg.sv
`default_nettype none
// ============================================================================
// esw_pkg : shared word tags, data width and arbiter FSM encoding.
// Revision: 1.0
// ============================================================================
package esw_pkg;

  localparam int DATA_W = 134;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  function automatic logic [1:0] word_tag(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/esw_rr_pick.sv
`default_nettype none
// ============================================================================
// esw_rr_pick : 4-way round-robin pick, first request at or above ptr_i.
// Revision: 1.0
// ============================================================================
module esw_rr_pick
  import esw_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] gnt_o,
  output logic       any_o
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    gnt_o   = ptr_i;
    w_found = 1'b0;
    w_idx   = ptr_i;
    for (int i = 0; i < 4; i++) begin
      w_idx = ptr_i + 2'(i);
      if (!w_found && req_i[w_idx]) begin
        gnt_o   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/esw_in_arb.sv
`default_nettype none
// ============================================================================
// esw_in_arb : packet-level round-robin merge of four ingress queues.
// Option macro ESW_ARB_STRICT_PRIO_EN gives port 0 strict priority.
// Revision: 1.0
// ============================================================================
module esw_in_arb
  import esw_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_data_3,
  output logic              out_data_rd_0,
  output logic              out_data_rd_1,
  output logic              out_data_rd_2,
  output logic              out_data_rd_3,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  input  logic              in_valid_empty_0,
  input  logic              in_valid_empty_1,
  input  logic              in_valid_empty_2,
  input  logic              in_valid_empty_3,
  output logic              out_valid_rd_0,
  output logic              out_valid_rd_1,
  output logic              out_valid_rd_2,
  output logic              out_valid_rd_3,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  input  logic              in_alf,
  output logic [CNT_W-1:0]  arb_pkt_cnt_0,
  output logic [CNT_W-1:0]  arb_pkt_cnt_1,
  output logic [CNT_W-1:0]  arb_pkt_cnt_2,
  output logic [CNT_W-1:0]  arb_pkt_cnt_3
);

  logic [DATA_W-1:0] w_data [4];
  logic [3:0]        w_valid;
  logic [3:0]        w_req;
  logic [3:0]        w_pick_req;
  logic [1:0]        w_rr_gnt;
  logic              w_pick_any;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_rr_upd;
  logic [DATA_W-1:0] w_cur;
  logic              w_cur_valid;
  logic              w_send;
  logic [3:0]        w_data_rd;
  logic [3:0]        w_valid_rd;

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_data_wr_q, out_data_wr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_valid_wr_q, out_valid_wr_d;
  logic [CNT_W-1:0]  cnt_q [4];

  assign w_data[0] = in_data_0;
  assign w_data[1] = in_data_1;
  assign w_data[2] = in_data_2;
  assign w_data[3] = in_data_3;
  assign w_valid   = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
  assign w_req     = ~{in_valid_empty_3, in_valid_empty_2,
                       in_valid_empty_1, in_valid_empty_0};

`ifdef ESW_ARB_STRICT_PRIO_EN
  // Port 0 bypasses the rotation; the pointer only tracks ports 1-3.
  assign w_pick_req = {w_req[3:1], 1'b0};
  assign w_gnt      = w_req[0] ? 2'd0 : w_rr_gnt;
  assign w_any      = w_req[0] | w_pick_any;
  assign w_rr_upd   = (gnt_q != 2'd0);
`else
  assign w_pick_req = w_req;
  assign w_gnt      = w_rr_gnt;
  assign w_any      = w_pick_any;
  assign w_rr_upd   = 1'b1;
`endif

  esw_rr_pick u_pick (
    .req_i (w_pick_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (w_rr_gnt),
    .any_o (w_pick_any)
  );

  assign w_cur       = w_data[gnt_q];
  assign w_cur_valid = w_valid[gnt_q];
  assign w_send      = (state_q == SEND) && !in_alf;
  assign w_data_rd   = w_send ? (4'b0001 << gnt_q) : 4'b0000;
  assign w_valid_rd  = (state_q == VALID) ? (4'b0001 << gnt_q) : 4'b0000;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_ptr_d       = rr_ptr_q;
    out_data_d     = out_data_q;
    out_data_wr_d  = 1'b0;
    out_valid_d    = out_valid_q;
    out_valid_wr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!in_alf && w_any) begin
          gnt_d   = w_gnt;
          state_d = SEND;
        end
      end
      SEND: begin
        if (w_send) begin
          out_data_d    = w_cur;
          out_data_wr_d = 1'b1;
          if (word_tag(w_cur) == TAG_TAIL) begin
            state_d = VALID;
          end
        end
      end
      VALID: begin
        out_valid_d    = w_cur_valid;
        out_valid_wr_d = 1'b1;
        if (w_rr_upd) begin
          rr_ptr_d = gnt_q + 2'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      gnt_q          <= 2'd0;
      rr_ptr_q       <= 2'd0;
      out_data_q     <= '0;
      out_data_wr_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      out_valid_wr_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      rr_ptr_q       <= rr_ptr_d;
      out_data_q     <= out_data_d;
      out_data_wr_q  <= out_data_wr_d;
      out_valid_q    <= out_valid_d;
      out_valid_wr_q <= out_valid_wr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_valid_rd[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign out_data_rd_0  = w_data_rd[0];
  assign out_data_rd_1  = w_data_rd[1];
  assign out_data_rd_2  = w_data_rd[2];
  assign out_data_rd_3  = w_data_rd[3];
  assign out_valid_rd_0 = w_valid_rd[0];
  assign out_valid_rd_1 = w_valid_rd[1];
  assign out_valid_rd_2 = w_valid_rd[2];
  assign out_valid_rd_3 = w_valid_rd[3];
  assign out_data       = out_data_q;
  assign out_data_wr    = out_data_wr_q;
  assign out_valid      = out_valid_q;
  assign out_valid_wr   = out_valid_wr_q;
  assign arb_pkt_cnt_0  = cnt_q[0];
  assign arb_pkt_cnt_1  = cnt_q[1];
  assign arb_pkt_cnt_2  = cnt_q[2];
  assign arb_pkt_cnt_3  = cnt_q[3];

endmodule
`default_nettype wire

// File: tb/tb_esw_in_arb.sv
`default_nettype none
// ============================================================================
// tb_esw_in_arb : directed bench for esw_in_arb with show-ahead FIFO models.
// Revision: 1.0
// ============================================================================
module tb_esw_in_arb;
  import esw_pkg::*;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] tb_data [4];
  logic [3:0]        tb_valid;
  logic [3:0]        tb_vempty;
  logic              in_alf;
  logic [3:0]        drd, vrd;
  logic [DATA_W-1:0] out_data;
  logic              out_data_wr, out_valid, out_valid_wr;
  logic [CNT_W-1:0]  cnt [4];

  esw_in_arb #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_data_0        (tb_data[0]),
    .in_data_1        (tb_data[1]),
    .in_data_2        (tb_data[2]),
    .in_data_3        (tb_data[3]),
    .out_data_rd_0    (drd[0]),
    .out_data_rd_1    (drd[1]),
    .out_data_rd_2    (drd[2]),
    .out_data_rd_3    (drd[3]),
    .in_valid_0       (tb_valid[0]),
    .in_valid_1       (tb_valid[1]),
    .in_valid_2       (tb_valid[2]),
    .in_valid_3       (tb_valid[3]),
    .in_valid_empty_0 (tb_vempty[0]),
    .in_valid_empty_1 (tb_vempty[1]),
    .in_valid_empty_2 (tb_vempty[2]),
    .in_valid_empty_3 (tb_vempty[3]),
    .out_valid_rd_0   (vrd[0]),
    .out_valid_rd_1   (vrd[1]),
    .out_valid_rd_2   (vrd[2]),
    .out_valid_rd_3   (vrd[3]),
    .out_data         (out_data),
    .out_data_wr      (out_data_wr),
    .out_valid        (out_valid),
    .out_valid_wr     (out_valid_wr),
    .in_alf           (in_alf),
    .arb_pkt_cnt_0    (cnt[0]),
    .arb_pkt_cnt_1    (cnt[1]),
    .arb_pkt_cnt_2    (cnt[2]),
    .arb_pkt_cnt_3    (cnt[3])
  );

  logic [DATA_W-1:0] dq [4][$];
  logic              vq [4][$];
  logic [DATA_W:0]   ev [$];
  logic [3:0]        last_drd, last_vrd;
  int                drd_cnt [4];
  int                vrd_cnt [4];
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic check(input string tag, input logic [DATA_W:0] got, input logic [DATA_W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mkw(input logic [1:0] t, input logic [3:0] p, input logic [3:0] s);
    return {t, {(DATA_W-10){1'b0}}, p, s};
  endfunction

  function automatic logic [DATA_W:0] dev(input logic [DATA_W-1:0] w);
    return {1'b0, w};
  endfunction

  function automatic logic [DATA_W:0] vev(input logic v);
    return {1'b1, {(DATA_W-1){1'b0}}, v};
  endfunction

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      tb_data[i]   = (dq[i].size() != 0) ? dq[i][0] : '0;
      tb_vempty[i] = (vq[i].size() == 0);
      tb_valid[i]  = (vq[i].size() != 0) ? vq[i][0] : 1'b0;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      drd_cnt[i] = 0;
      vrd_cnt[i] = 0;
    end
  endtask

  // One clock: pop what the DUT strobed at the edge, then sample outputs.
  task automatic step();
    @(posedge clk);
    last_drd = drd;
    last_vrd = vrd;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (last_drd[i]) begin
        drd_cnt[i]++;
        if (dq[i].size() != 0) void'(dq[i].pop_front());
      end
      if (last_vrd[i]) begin
        vrd_cnt[i]++;
        if (vq[i].size() != 0) void'(vq[i].pop_front());
      end
    end
    refresh();
    #1;
    if (out_data_wr)  ev.push_back(dev(out_data));
    if (out_valid_wr) ev.push_back(vev(out_valid));
    check("wr_excl", out_data_wr & out_valid_wr, 0);
    check("pop_excl", (|last_drd) & (|last_vrd), 0);
  endtask

  task automatic push_pkt(input int p, input int n, input logic v);
    logic [1:0] t;
    for (int k = 0; k < n; k++) begin
      t = (k == n - 1) ? TAG_TAIL : ((k == 0) ? TAG_HEAD : TAG_BODY);
      dq[p].push_back(mkw(t, 4'(p), 4'(k)));
    end
    vq[p].push_back(v);
    refresh();
  endtask

  task automatic wait_ev(input string nm, input int n, input int limit);
    int k;
    k = 0;
    while (ev.size() < n && k < limit) begin
      step();
      k++;
    end
    check({nm, "_timeout"}, ev.size() >= n, 1);
  endtask

  // Single-word packets with valid=1, expected grant order packed 2 bits per packet.
  task automatic check_order(input string nm, input int n, input logic [7:0] order);
    logic [1:0] p;
    wait_ev(nm, 2 * n, 10 * n);
    for (int k = 0; k < n; k++) begin
      p = order[2*k +: 2];
      check($sformatf("%s_word%0d", nm, k), ev[2*k], dev(mkw(TAG_TAIL, {2'b00, p}, 4'd0)));
      check($sformatf("%s_valid%0d", nm, k), ev[2*k+1], vev(1'b1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    in_alf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dq[i].delete();
      vq[i].delete();
    end
    refresh();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    ev.delete();
    clear_counts();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] exp_w [3];
    in_alf = 1'b0;
    refresh();
    clear_counts();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_data_wr", out_data_wr, 0);
    check("rst_valid_wr", out_valid_wr, 0);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rd", {drd, vrd}, 0);
    check("rst_cnt", {cnt[0], cnt[1], cnt[2], cnt[3]}, 0);
    rst = 1'b0;
    step();
    ev.delete();
    clear_counts();

    // Single 3-word packet on port 2
    exp_w[0] = mkw(TAG_HEAD, 4'd2, 4'd0);
    exp_w[1] = mkw(TAG_BODY, 4'd2, 4'd1);
    exp_w[2] = mkw(TAG_TAIL, 4'd2, 4'd2);
    push_pkt(2, 3, 1'b1);
    for (int s = 1; s <= 6; s++) begin
      step();
      check($sformatf("t1_wr%0d", s), out_data_wr, (s >= 2 && s <= 4));
      check($sformatf("t1_vwr%0d", s), out_valid_wr, (s == 5));
      if (s >= 2 && s <= 4) check($sformatf("t1_data%0d", s), out_data, exp_w[s-2]);
      if (s == 5) check("t1_valid", out_valid, 1);
    end
    check("t1_cnt2", cnt[2], 1);
    check("t1_drd2", drd_cnt[2], 3);
    check("t1_vrd2", vrd_cnt[2], 1);

    // Fairness: two 2-word packets queued on every port
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) push_pkt(p, 2, 1'b1);
    wait_ev("t2", 24, 80);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_head%0d", k), ev[3*k],   dev(mkw(TAG_HEAD, 4'(k % 4), 4'd0)));
      check($sformatf("t2_tail%0d", k), ev[3*k+1], dev(mkw(TAG_TAIL, 4'(k % 4), 4'd1)));
      check($sformatf("t2_valid%0d", k), ev[3*k+2], vev(1'b1));
    end
    for (int p = 0; p < 4; p++) check($sformatf("t2_cnt%0d", p), cnt[p], 2);

    // Dropped single-word packet on port 1
    ev.delete();
    clear_counts();
    push_pkt(1, 1, 1'b0);
    wait_ev("t3", 2, 20);
    step();
    step();
    check("t3_nev", ev.size(), 2);
    check("t3_word", ev[0], dev(mkw(TAG_TAIL, 4'd1, 4'd0)));
    check("t3_valid", ev[1], vev(1'b0));
    check("t3_drd1", drd_cnt[1], 1);
    check("t3_vrd1", vrd_cnt[1], 1);
    check("t3_cnt1", cnt[1], 3);

    // Backpressure: 5-cycle stall after word 2 of 4 on port 0
    ev.delete();
    clear_counts();
    push_pkt(0, 4, 1'b1);
    wait_ev("t4a", 2, 20);
    in_alf = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      check($sformatf("t4_stall_wr%0d", s), out_data_wr, 0);
      check($sformatf("t4_stall_rd%0d", s), last_drd, 0);
    end
    check("t4_stall_nev", ev.size(), 2);
    in_alf = 1'b0;
    wait_ev("t4b", 5, 20);
    check("t4_w0", ev[0], dev(mkw(TAG_HEAD, 4'd0, 4'd0)));
    check("t4_w1", ev[1], dev(mkw(TAG_BODY, 4'd0, 4'd1)));
    check("t4_w2", ev[2], dev(mkw(TAG_BODY, 4'd0, 4'd2)));
    check("t4_w3", ev[3], dev(mkw(TAG_TAIL, 4'd0, 4'd3)));
    check("t4_valid", ev[4], vev(1'b1));
    check("t4_drd0", drd_cnt[0], 4);

    // Asynchronous reset during word 2 of a 5-word packet on port 3
    ev.delete();
    clear_counts();
    push_pkt(3, 5, 1'b1);
    wait_ev("t5a", 2, 20);
    #1;
    rst = 1'b1;
    #1;
    check("t5_data", out_data, 0);
    check("t5_data_wr", out_data_wr, 0);
    check("t5_valid", out_valid, 0);
    check("t5_rd", {drd, vrd}, 0);
    check("t5_cnt", {cnt[0], cnt[1], cnt[2], cnt[3]}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dq[i].delete();
      vq[i].delete();
    end
    refresh();
    step();
    step();
    check("t5_idle_wr", out_data_wr, 0);
    check("t5_idle_rd", last_drd, 0);
    // A surviving pointer of 1 would pick port 3 ahead of port 0.
    ev.delete();
    push_pkt(3, 1, 1'b1);
    push_pkt(0, 1, 1'b1);
    check_order("t5_order", 2, 8'b0000_1100);

`ifdef ESW_ARB_STRICT_PRIO_EN
    ev.delete();
    push_pkt(3, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    push_pkt(0, 1, 1'b1);
    push_pkt(0, 1, 1'b1);
    check_order("t6_prio", 4, 8'b11_11_00_00);
    ev.delete();
    push_pkt(1, 1, 1'b1);
    push_pkt(1, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    check_order("t6_alt", 4, 8'b11_01_11_01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
